// File: rtl/axil_sram_slave.sv
// axil_sram_slave: AXI4-Lite slave in front of a byte-writable word memory.
// Independent read and write FSMs, each with one outstanding transaction and
// a programmable wait between request acceptance and response.
module axil_sram_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  // write address channel
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  // write data channel
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  // write response channel
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  // read address channel
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  // read data channel
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int                STRB_W      = DATA_W / 8;
  localparam int                BYTE_SH     = $clog2(STRB_W);
  localparam int                IDX_W       = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(DEPTH);
  localparam logic [3:0]        RD_LAT_C    = 4'(RD_LAT);
  localparam logic [3:0]        WR_LAT_C    = 4'(WR_LAT);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_WAIT, W_RESP} wr_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte address -> word index; sub-word address bits are dropped.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> BYTE_SH);
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    w = a >> BYTE_SH;
    return w < DEPTH_A;
  endfunction

  // ---------------------------------------------------------------- read side
  rd_state_e         rd_state_q, rd_state_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ADDR_W-1:0] rd_addr_eff;
  logic              rd_capture;

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // Read next-state: accept AR, count down the latency, then capture the word.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    rd_state_d  = rd_state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_addr_d   = rd_addr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_addr_eff = rd_addr_q;
    rd_capture  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rd_addr_d   = araddr;
          rd_addr_eff = araddr;
          if (RD_LAT == 0) begin
            rd_state_d = R_RESP;
            rd_capture = 1'b1;
          end else begin
            rd_state_d = R_WAIT;
            rd_cnt_d   = RD_LAT_C;
          end
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - 4'd1;
        if (rd_cnt_q == 4'd1) begin
          rd_state_d = R_RESP;
          rd_capture = 1'b1;
        end
      end
      R_RESP: begin
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    // Captured from the array before any same-edge write lands: old data wins.
    if (rd_capture) begin
      if (addr_ok(rd_addr_eff)) begin
        rdata_d = mem[word_idx(rd_addr_eff)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  // Read state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the pre-edge values.
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_e         wr_state_q, wr_state_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              collecting;
  logic              wr_commit;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;

  assign collecting = (wr_state_q == W_IDLE) || (wr_state_q == W_COLLECT);
  assign awready    = collecting && !aw_held_q;
  assign wready     = collecting && !w_held_q;
  assign bvalid     = (wr_state_q == W_RESP);
  assign bresp      = bresp_q;

  // Write next-state: gather AW and W in any order, wait, commit, respond.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    mem_we     = 1'b0;
    if (awvalid && awready) begin
      aw_held_d = 1'b1;
      wr_addr_d = awaddr;
    end
    if (wvalid && wready) begin
      w_held_d  = 1'b1;
      wr_data_d = wdata;
      wr_strb_d = wstrb;
    end
    unique case (wr_state_q)
      W_IDLE, W_COLLECT: begin
        if (aw_held_d && w_held_d) begin
          if (WR_LAT == 0) begin
            wr_state_d = W_RESP;
            wr_commit  = 1'b1;
          end else begin
            wr_state_d = W_WAIT;
            wr_cnt_d   = WR_LAT_C;
          end
        end else if (aw_held_d || w_held_d) begin
          wr_state_d = W_COLLECT;
        end
      end
      W_WAIT: begin
        wr_cnt_d = wr_cnt_q - 4'd1;
        if (wr_cnt_q == 4'd1) begin
          wr_state_d = W_RESP;
          wr_commit  = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (wr_commit) begin
      bresp_d = addr_ok(wr_addr_d) ? RESP_OKAY : RESP_SLVERR;
      // A reset arriving mid-transaction must never let the write land.
      mem_we  = addr_ok(wr_addr_d) && !rst;
    end
  end

  assign mem_idx = word_idx(wr_addr_d);

  // Write state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      bresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Byte-masked memory write on entry to W_RESP.
  // NOTE: the array has no reset so it maps onto plain RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb_d[b]) mem[mem_idx][8*b +: 8] <= wr_data_d[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Self-checking bench for axil_sram_slave: directed scenarios plus a randomized
// read/write mix checked against a byte-level reference memory.
module tb_axil_sram_slave;

  localparam int RD_LAT = 1;
  localparam int WR_LAT = 1;
  localparam int DEPTH  = 1024;
  localparam int TMO    = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready = 1'b0;

  // second instance: 64-bit, non-power-of-two depth, RD_LAT=3, read side only
  logic [31:0] araddr3 = '0;
  logic        arvalid3 = 1'b0, arready3;
  logic [63:0] rdata3;
  logic [1:0]  rresp3, bresp3;
  logic        rvalid3, rready3 = 1'b0, awready3, wready3, bvalid3;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  axil_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  axil_sram_slave #(.DATA_W(64), .ADDR_W(32), .DEPTH(1000), .RD_LAT(3), .WR_LAT(0)) u_dut3 (
    .clk(clk), .rst(rst),
    .awaddr(32'h0), .awvalid(1'b0), .awready(awready3),
    .wdata(64'h0), .wstrb(8'h0), .wvalid(1'b0), .wready(wready3),
    .bresp(bresp3), .bvalid(bvalid3), .bready(1'b0),
    .araddr(araddr3), .arvalid(arvalid3), .arready(arready3),
    .rdata(rdata3), .rresp(rresp3), .rvalid(rvalid3), .rready(rready3)
  );

  // Reference memory: word index -> contents, updated byte by byte.
  logic [31:0] ref_mem [int];

  function automatic logic ref_in_range(input logic [31:0] addr);
    return (addr >> 2) < DEPTH;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    logic [31:0] w;
    if (!ref_in_range(addr)) return;
    idx = int'(addr >> 2);
    w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    ref_mem[idx] = w;
  endtask

  task automatic timeout_fail(input string what);
    n_cmp++; n_mis++;
    $display("FAIL %s: handshake wait exceeded %0d cycles", what, TMO);
  endtask

  // Full write transaction, AW and W presented together.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < TMO) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    if (awvalid || wvalid) begin timeout_fail("write_addr_data"); awvalid = 1'b0; wvalid = 1'b0; end
    n = 0;
    while (!bvalid && n < TMO) begin @(negedge clk); n++; end
    if (!bvalid) timeout_fail("write_bvalid");
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Full read transaction; lat counts cycles from the AR handshake cycle to rvalid.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < TMO) begin @(negedge clk); n++; end
    if (!arready) timeout_fail("read_ar");
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < TMO) begin @(negedge clk); lat++; end
    if (!rvalid) timeout_fail("read_rvalid");
    data = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (arready !== 1'b1) begin n_mis++; $display("FAIL reset_arready: got %b want 1", arready); end
    n_cmp++; if (awready !== 1'b1) begin n_mis++; $display("FAIL reset_awready: got %b want 1", awready); end
    n_cmp++; if (wready !== 1'b1)  begin n_mis++; $display("FAIL reset_wready: got %b want 1", wready); end
    n_cmp++; if (rvalid !== 1'b0)  begin n_mis++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (bvalid !== 1'b0)  begin n_mis++; $display("FAIL reset_bvalid: got %b want 0", bvalid); end
    n_cmp++; if (rdata !== 32'h0)  begin n_mis++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (rresp !== 2'b00)  begin n_mis++; $display("FAIL reset_rresp: got %b want 00", rresp); end
    n_cmp++; if (bresp !== 2'b00)  begin n_mis++; $display("FAIL reset_bresp: got %b want 00", bresp); end
    n_cmp++; if ({arready3, awready3, wready3, rvalid3, bvalid3} !== 5'b11100)
      begin n_mis++; $display("FAIL reset_dut3_hs: got %b want 11100", {arready3, awready3, wready3, rvalid3, bvalid3}); end
    n_cmp++; if (rdata3 !== 64'h0) begin n_mis++; $display("FAIL reset_dut3_rdata: got %h want 0", rdata3); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(32'h64, 32'h0000001E, 4'hF, r); ref_write(32'h64, 32'h0000001E, 4'hF);
    n_cmp++; if (r !== 2'b00) begin n_mis++; $display("FAIL basic_bresp: got %b want 00", r); end
    axi_read(32'h64, d, r, lat);
    n_cmp++; if (d !== 32'h0000001E) begin n_mis++; $display("FAIL basic_rdata: got %h want 0000001e", d); end
    n_cmp++; if (r !== 2'b00) begin n_mis++; $display("FAIL basic_rresp: got %b want 00", r); end
    n_cmp++; if (lat !== RD_LAT + 1) begin n_mis++; $display("FAIL basic_rd_latency: got %0d want %0d", lat, RD_LAT + 1); end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(32'h10, 32'hAABBCCDD, 4'b1111, r); ref_write(32'h10, 32'hAABBCCDD, 4'b1111);
    axi_write(32'h10, 32'h11223344, 4'b0101, r); ref_write(32'h10, 32'h11223344, 4'b0101);
    axi_read(32'h10, d, r, lat);
    n_cmp++; if (d !== 32'hAA22CC44) begin n_mis++; $display("FAIL strobe_merge: got %h want aa22cc44", d); end
    axi_write(32'h12, 32'h55555555, 4'b0000, r);
    n_cmp++; if (r !== 2'b00) begin n_mis++; $display("FAIL strobe_zero_bresp: got %b want 00", r); end
    axi_read(32'h13, d, r, lat);
    n_cmp++; if (d !== 32'hAA22CC44) begin n_mis++; $display("FAIL strobe_zero_nochange: got %h want aa22cc44", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(32'h0, 32'hCAFEF00D, 4'hF, r); ref_write(32'h0, 32'hCAFEF00D, 4'hF);
    axi_read(32'h1000, d, r, lat);
    n_cmp++; if (r !== 2'b10) begin n_mis++; $display("FAIL oor_rresp: got %b want 10", r); end
    n_cmp++; if (d !== 32'h0) begin n_mis++; $display("FAIL oor_rdata: got %h want 0", d); end
    axi_write(32'h1000, 32'hDEADBEEF, 4'hF, r);
    n_cmp++; if (r !== 2'b10) begin n_mis++; $display("FAIL oor_bresp: got %b want 10", r); end
    axi_read(32'h0, d, r, lat);
    n_cmp++; if (d !== 32'hCAFEF00D) begin n_mis++; $display("FAIL oor_mem_unchanged: got %h want cafef00d", d); end
    axi_write(32'hFFC, 32'h0BADCAFE, 4'hF, r);
    n_cmp++; if (r !== 2'b00) begin n_mis++; $display("FAIL last_word_bresp: got %b want 00", r); end
    axi_read(32'hFFF, d, r, lat);
    n_cmp++; if ({r, d} !== {2'b00, 32'h0BADCAFE}) begin n_mis++; $display("FAIL last_word_read: got %b/%h want 00/0badcafe", r, d); end
  endtask

  // W one cycle ahead of AW, then B held off for 5 cycles with a stray W pending.
  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d; int lat, n;
    @(negedge clk);
    wdata = 32'h13579BDF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    n_cmp++; if ({awready, wready} !== 2'b10) begin n_mis++; $display("FAIL wfirst_ready: got %b want 10", {awready, wready}); end
    awaddr = 32'h300; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 32'hFFFFFFFF; wvalid = 1'b1;  // must not be taken before the B handshake
    n = 0;
    while (!bvalid && n < TMO) begin
      n_cmp++; if ({awready, wready} !== 2'b00) begin n_mis++; $display("FAIL wfirst_wait_ready: got %b want 00", {awready, wready}); end
      @(negedge clk); n++;
    end
    if (!bvalid) timeout_fail("wfirst_bvalid");
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({bvalid, bresp, awready, wready} !== 5'b10000)
        begin n_mis++; $display("FAIL wfirst_hold%0d: got %b want 10000", i, {bvalid, bresp, awready, wready}); end
      @(negedge clk);
    end
    bready = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    bready = 1'b0;
    n_cmp++; if ({bvalid, awready, wready} !== 3'b011) begin n_mis++; $display("FAIL wfirst_release: got %b want 011", {bvalid, awready, wready}); end
    ref_write(32'h300, 32'h13579BDF, 4'hF);
    axi_read(32'h300, d, r, lat);
    n_cmp++; if (d !== ref_mem[32'h300 >> 2]) begin n_mis++; $display("FAIL wfirst_data: got %h want %h", d, ref_mem[32'h300 >> 2]); end
  endtask

  // RD_LAT=3 instance: latency, rready stall stability, no second AR taken.
  task automatic test_rd_hold();
    logic [31:0] addr_t [2];
    logic [1:0]  resp_t [2];
    int lat;
    logic ar_seen;
    addr_t[0] = 32'd8000; resp_t[0] = 2'b10;   // word 1000: first out-of-range word
    addr_t[1] = 32'd7997; resp_t[1] = 2'b00;   // word 999: last word, unaligned
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      araddr3 = addr_t[i]; arvalid3 = 1'b1; rready3 = 1'b0;
      @(negedge clk);
      araddr3 = 32'h0;                        // second AR kept pending
      ar_seen = 1'b0;
      lat = 1;
      while (!rvalid3 && lat < TMO) begin ar_seen |= arready3; @(negedge clk); lat++; end
      n_cmp++; if (lat !== 4) begin n_mis++; $display("FAIL hold%0d_latency: got %0d want 4", i, lat); end
      for (int c = 0; c < 4; c++) begin
        ar_seen |= arready3;
        n_cmp++; if ({rvalid3, rresp3} !== {1'b1, resp_t[i]})
          begin n_mis++; $display("FAIL hold%0d_c%0d: got %b want %b", i, c, {rvalid3, rresp3}, {1'b1, resp_t[i]}); end
        if (i == 0) begin
          n_cmp++; if (rdata3 !== 64'h0) begin n_mis++; $display("FAIL hold0_rdata_c%0d: got %h want 0", c, rdata3); end
        end
        @(negedge clk);
      end
      n_cmp++; if (ar_seen !== 1'b0) begin n_mis++; $display("FAIL hold%0d_arready: got %b want 0", i, ar_seen); end
      arvalid3 = 1'b0; rready3 = 1'b1;
      @(negedge clk);
      rready3 = 1'b0;
      n_cmp++; if ({rvalid3, arready3} !== 2'b01) begin n_mis++; $display("FAIL hold%0d_release: got %b want 01", i, {rvalid3, arready3}); end
    end
  endtask

  // Read capture and write commit on the same edge return the old word.
  task automatic test_concurrent();
    logic [1:0] wr_r, rd_r; logic [31:0] d; int lat;
    axi_write(32'h200, 32'h0A0A0A0A, 4'hF, wr_r); ref_write(32'h200, 32'h0A0A0A0A, 4'hF);
    fork
      axi_write(32'h200, 32'hB0B0B0B0, 4'hF, wr_r);
      axi_read(32'h200, d, rd_r, lat);
    join
    n_cmp++; if (d !== 32'h0A0A0A0A) begin n_mis++; $display("FAIL concurrent_old_data: got %h want 0a0a0a0a", d); end
    n_cmp++; if (lat !== RD_LAT + 1) begin n_mis++; $display("FAIL concurrent_latency: got %0d want %0d", lat, RD_LAT + 1); end
    ref_write(32'h200, 32'hB0B0B0B0, 4'hF);
    axi_read(32'h200, d, rd_r, lat);
    n_cmp++; if (d !== 32'hB0B0B0B0) begin n_mis++; $display("FAIL concurrent_new_data: got %h want b0b0b0b0", d); end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(32'h20, 32'h99, 4'hF, r); ref_write(32'h20, 32'h99, 4'hF);
    @(negedge clk);
    awaddr = 32'h20; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);                 // both accepted: write is now waiting
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} !== {3'b110, 2'b00, 2'b10, 2'b00, 32'h0})
      begin n_mis++; $display("FAIL midrst_outputs: got %b want %b", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata},
                              {3'b110, 2'b00, 2'b10, 2'b00, 32'h0}); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; bready = 1'b0;
    axi_read(32'h20, d, r, lat);
    n_cmp++; if (d !== 32'h99) begin n_mis++; $display("FAIL midrst_no_commit: got %h want 00000099", d); end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] a, d, ed; logic [3:0] s; int lat, idx;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      axi_write(32'h400 + 32'(i * 4), d, 4'hF, r); ref_write(32'h400 + 32'(i * 4), d, 4'hF);
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + $urandom_range(0, 32'hFFFF);
      else a = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      er = ref_in_range(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, r); ref_write(a, d, s);
        n_cmp++; if (r !== er) begin n_mis++; $display("FAIL rand%0d_bresp @%h: got %b want %b", i, a, r, er); end
      end else begin
        idx = int'(a >> 2);
        ed = ref_in_range(a) ? ref_mem[idx] : 32'h0;
        axi_read(a, d, r, lat);
        n_cmp++; if ({r, d} !== {er, ed}) begin n_mis++; $display("FAIL rand%0d_read @%h: got %b/%h want %b/%h", i, a, r, d, er, ed); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_out_of_range();
    test_w_before_aw();
    test_rd_hold();
    test_concurrent();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL global_timeout: simulation did not complete within 500us");
    $fatal(1, "timeout");
  end

endmodule
